hazard_scoreboard_unit: RTL
===========================

Name: hazard_scoreboard_unit

Overview:
Next-generation pipeline hazard unit for the RV32 pipelined core. It keeps load-use and branch/jump RAW stall detection, and adds three things:
- a per-register scoreboard for the iterative multi-cycle mul/div unit;
- a structural stall for that unit;
- flush awareness.

It sits in ID beside the register file and drives the PC, IF/ID and ID/EX-control enables. The branch-resolution stage is a parameter.

Parameters:
- NUM_REGS, 32, architectural register count; x0 is hardwired zero.
- REG_AW, 5, register address width; must satisfy 2**REG_AW >= NUM_REGS.
- MD_LATENCY, 4, mul/div cycles from issue to writeback; legal range 1..15.
- BRANCH_IN_ID, 1, 1 = branches/jumps resolve in ID and need operands ready; 0 = resolve in EX with forwarding, no branch stall.
- CNT_W, 32, width of the stall statistics counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ID_valid  in  1  ID holds a real instruction
- ID_opcode  in  7  opcode of the ID instruction
- ID_rs1, ID_rs2  in  REG_AW  source registers of the ID instruction
- ID_rs1_used, ID_rs2_used  in  1  qualify each source as actually read
- ID_rd  in  REG_AW  destination of the ID instruction
- ID_regWrite  in  1  ID instruction writes rd
- ID_isMulDiv  in  1  ID instruction goes to the mul/div unit
- EX_memRead, EX_regWrite  in  1  controls of the instruction in EX
- EX_rd  in  REG_AW  destination of the instruction in EX
- MEM_regWrite  in  1  write enable of the instruction in MEM
- MEM_rd  in  REG_AW  destination of the instruction in MEM
- flush  in  1  taken branch/jump in EX; squashes the instruction in ID
- PCWrite, IF_ID_Write, EX_control  out  1  1 = advance; 0 = hold PC/IF_ID and bubble ID/EX control
- md_busy  out  1  mul/div unit occupied
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: rst is synchronous and active-high.
  - pending[] = 0, md_cnt = 0, md_tag = 0, stall_count = 0.
  - While rst = 1: PCWrite, IF_ID_Write and EX_control are forced to 1, and md_busy = 0.
- Match rule: src_hit(r) = r != 0 and r == ID_rs1 with ID_rs1_used, or r == ID_rs2 with ID_rs2_used.
- Stall causes (combinational), all gated by ID_valid & ~flush:
  - Branch: BRANCH_IN_ID = 1, ID_opcode is 1100011, 1100111 or 1101111, and either (EX_regWrite & src_hit(EX_rd)) or (MEM_regWrite & src_hit(MEM_rd)).
  - Load-use: EX_memRead & src_hit(EX_rd). Applies to every opcode, branches included.
  - Scoreboard RAW: pending[ID_rs1] with ID_rs1_used, or pending[ID_rs2] with ID_rs2_used.
  - Scoreboard WAW: ID_regWrite & ID_rd != 0 & pending[ID_rd].
  - Structural: ID_isMulDiv & md_busy.
- stall = OR of all causes. PCWrite = IF_ID_Write = EX_control = ~stall. There is no registered latency on these outputs.
- flush = 1: stall is forced to 0 and no issue happens that cycle. An in-flight mul/div op is older than the branch and is never cancelled.
- Mul/div issue: on a clock edge with ID_valid & ID_isMulDiv & ~stall & ~flush:
  - md_cnt <= MD_LATENCY and md_tag <= ID_rd.
  - If ID_regWrite & ID_rd != 0, pending[ID_rd] <= 1.
- Countdown: md_busy = (md_cnt != 0). Each cycle md_cnt > 0, md_cnt decrements.
  - The cycle with md_cnt = 1 is the writeback cycle; pending[md_tag] clears at its closing edge.
  - A dependent instruction waiting in ID proceeds in the following cycle.
- Stall timing: a dependent instruction entering ID right after the mul/div issue stalls exactly MD_LATENCY cycles.
- No overlap: busy blocks any new issue, including in the md_cnt = 1 cycle. Set and clear of the same pending bit can therefore never coincide.
- x0: pending[0] is never set; x0 matches never stall.
- Reset mid-operation: clears scoreboard and counter immediately. The op in flight is abandoned.
- stall_count: increments on every cycle with stall = 1 (rst = 0) and saturates at all-ones.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: stall_count is implemented as described above.
- Undefined: no counter register is built; stall_count is constant 0.

Test Plan:
1. Load-use: EX_memRead = 1, EX_rd = 5, ID_rs1 = 5 used → one cycle with PCWrite = IF_ID_Write = EX_control = 0; EX_rd = 0 → no stall.
2. Branch RAW: BRANCH_IN_ID = 1, ID_opcode = 1100011, MEM_regWrite = 1, MEM_rd = 7 = ID_rs2 → stall. Rebuild with BRANCH_IN_ID = 0 → no stall.
3. Scoreboard: MD_LATENCY = 4, issue mul writing x10, next instruction reads x10 → 4 stall cycles, md_busy high 4 cycles, proceeds on cycle 5; stall_count = 4.
4. Structural and WAW, each after a mul to x10 issues:
   - a second mul writing x11 → stalls until md_busy falls;
   - an add writing x10 → WAW stall.
5. Flush: flush = 1 in the same cycle as a load-use match → outputs all 1 and no mul/div issue; a pending mul still clears on schedule.
6. Reset mid-op: assert rst two cycles after mul issue → next cycle md_busy = 0, pending clear, stall_count = 0, no stall on x10 readers.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: load-use / branch RAW detection plus a mul/div scoreboard.
// Optional macro HAZARD_STATS_EN builds the saturating stall_count register.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS     = 32,
  parameter int REG_AW       = 5,
  parameter int MD_LATENCY   = 4,
  parameter int BRANCH_IN_ID = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_valid,
  input  logic [6:0]        ID_opcode,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic              ID_rs1_used,
  input  logic              ID_rs2_used,
  input  logic [REG_AW-1:0] ID_rd,
  input  logic              ID_regWrite,
  input  logic              ID_isMulDiv,
  input  logic              EX_memRead,
  input  logic              EX_regWrite,
  input  logic [REG_AW-1:0] EX_rd,
  input  logic              MEM_regWrite,
  input  logic [REG_AW-1:0] MEM_rd,
  input  logic              flush,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              EX_control,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [3:0]        MD_LAT_C  = 4'(MD_LATENCY);
  localparam logic [6:0]        OP_BRANCH = 7'b1100011;
  localparam logic [6:0]        OP_JALR   = 7'b1100111;
  localparam logic [6:0]        OP_JAL    = 7'b1101111;
  localparam logic [REG_AW-1:0] REG_X0    = {REG_AW{1'b0}};

  logic [NUM_REGS-1:0] pending_r;
  logic [3:0]          md_cnt_r;
  logic [REG_AW-1:0]   md_tag_r;

  logic is_branch_s;
  logic gate_s;
  logic md_busy_s;
  logic branch_stall_s;
  logic load_use_s;
  logic raw_s;
  logic waw_s;
  logic struct_s;
  logic stall_s;
  logic issue_s;

  function automatic logic src_hit(input logic [REG_AW-1:0] r,
                                   input logic [REG_AW-1:0] rs1,
                                   input logic [REG_AW-1:0] rs2,
                                   input logic              rs1_used,
                                   input logic              rs2_used);
    return (r != REG_X0) && (((r == rs1) && rs1_used) || ((r == rs2) && rs2_used));
  endfunction

  // Out-of-range register indices (NUM_REGS < 2**REG_AW) read as not pending.
  function automatic logic pend_at(input logic [NUM_REGS-1:0] vec,
                                   input logic [REG_AW-1:0]   idx);
    logic res;
    res = 1'b0;
    if (int'(idx) < NUM_REGS) begin
      res = vec[idx];
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

  // Decode the control-transfer opcodes that resolve in ID.
  always_comb begin
    is_branch_s = 1'b0;
    case (ID_opcode)
      OP_BRANCH, OP_JALR, OP_JAL: is_branch_s = 1'b1;
      default:                    is_branch_s = 1'b0;
    endcase
  end

  // Combine all stall causes; flush and reset suppress both stall and issue.
  always_comb begin
    md_busy_s      = (md_cnt_r != 4'd0);
    gate_s         = ID_valid & ~flush & ~rst;
    branch_stall_s = (BRANCH_IN_ID != 0) && is_branch_s &&
                     ((EX_regWrite  && src_hit(EX_rd,  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used)) ||
                      (MEM_regWrite && src_hit(MEM_rd, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used)));
    load_use_s     = EX_memRead && src_hit(EX_rd, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used);
    raw_s          = (ID_rs1_used && pend_at(pending_r, ID_rs1)) ||
                     (ID_rs2_used && pend_at(pending_r, ID_rs2));
    waw_s          = ID_regWrite && (ID_rd != REG_X0) && pend_at(pending_r, ID_rd);
    struct_s       = ID_isMulDiv && md_busy_s;
    stall_s        = gate_s & (branch_stall_s | load_use_s | raw_s | waw_s | struct_s);
    issue_s        = gate_s & ID_isMulDiv & ~stall_s;
    PCWrite        = ~stall_s;
    IF_ID_Write    = ~stall_s;
    EX_control     = ~stall_s;
    md_busy        = md_busy_s & ~rst;
  end

  // Mul/div countdown and scoreboard; busy blocks issue so set/clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NUM_REGS{1'b0}};
      md_cnt_r  <= 4'd0;
      md_tag_r  <= REG_X0;
    end else if (md_cnt_r != 4'd0) begin
      md_cnt_r <= md_cnt_r - 4'd1;
      if (md_cnt_r == 4'd1) begin
        pending_r[md_tag_r] <= 1'b0;
      end
    end else if (issue_s) begin
      md_cnt_r <= MD_LAT_C;
      md_tag_r <= ID_rd;
      if (ID_regWrite && (ID_rd != REG_X0) && (int'(ID_rd) < NUM_REGS)) begin
        pending_r[ID_rd] <= 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count_r;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = stall_count_r;
`else
  assign stall_count = {CNT_W{1'b0}};
`endif

endmodule
